// File: rtl/uart_program_loader_pkg.sv
// rtl/uart_program_loader_pkg.sv - shared types and constants for the UART program loader
// Purpose: loader and UART receiver state encodings plus the serial frame width.
// Ports: none (package).
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    LD_LEN,
    LD_DATA,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_program_loader_uart_rx.sv
// rtl/uart_program_loader_uart_rx.sv - 8N1 UART receiver with start-bit glitch rejection
// Purpose: synchronises rx, times bits at mid-bit and delivers one byte per good frame.
// Ports: clk, rst (sync, active high), rx (async serial in, idle high),
//        byte_valid (1-cycle pulse), byte_data (received byte), stop_err (1-cycle pulse on bad stop bit).
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      byte_valid,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      stop_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  uart_rx_state_t            state_q, state_d;
  logic [1:0]                sync_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      rx_s;

  assign rx_s       = sync_q[1];
  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign stop_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a line that has already gone high was a glitch.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          valid_d = rx_s;
          err_d   = !rx_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - boot loader writing a UART-delivered image into instruction memory
// Purpose: parses a little-endian word-count header and N payload words, writes each word
//          to imem and holds the core in reset until the image is complete.
// Ports: clk, rst (sync, active high), rx (serial in),
//        imem_we/imem_addr/imem_wdata (registered single-cycle write),
//        cpu_rst (core reset, high until DONE), loading, done (sticky), frame_err (sticky).
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_DEPTH   = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              loading,
  output logic              done,
  output logic              frame_err
);

  logic                      byte_valid;
  logic [UART_DATA_BITS-1:0] byte_data;
  logic                      stop_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  loader_state_t     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       part_q, part_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ferr_q, ferr_d;
  logic [31:0]       full_word;
  logic              word_complete;

  // Bytes shift in from the top, so byte k of a word lands in bits [8k+7:8k].
  assign full_word     = {byte_data, part_q};
  assign word_complete = byte_valid && (byte_cnt_q == 2'd3);

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign frame_err  = ferr_q;
  assign done       = (state_q == LD_DONE);
  assign cpu_rst    = (state_q != LD_DONE);
  assign loading    = ((state_q == LD_LEN) && (byte_cnt_q != 2'd0)) || (state_q == LD_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_LEN;
      byte_cnt_q <= '0;
      part_q     <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      part_q     <= part_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    part_d     = part_q;
    idx_d      = idx_q;
    last_d     = last_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ferr_d     = ferr_q | stop_err;
    case (state_q)
      LD_LEN: begin
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          part_d     = full_word[31:8];
        end
        if (word_complete) begin
          if ((full_word != 32'd0) && (full_word <= 32'(IMEM_DEPTH))) begin
            state_d = LD_DATA;
            idx_d   = '0;
            last_d  = ADDR_W'(full_word - 32'd1);
          end else begin
            state_d = LD_ERROR;
          end
        end
      end
      LD_DATA: begin
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          part_d     = full_word[31:8];
        end
        if (word_complete) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = full_word;
          idx_d   = idx_q + 1'b1;
        end
        // Leaving on the write cycle itself keeps DONE one cycle behind the final strobe.
        if (we_q && (addr_q == last_q)) state_d = LD_DONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - directed vector bench for uart_program_loader
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst, loading, done, frame_err;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .loading(loading), .done(done), .frame_err(frame_err)
  );

  // Write monitor, sampled on the falling edge.
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_done_at [64];
  logic        log_done_after [64];
  logic        log_cpu_after [64];
  int          nw = 0;
  int          b2b = 0;
  logic        we_prev = 1'b0;
  logic        pend = 1'b0;

  always @(negedge clk) begin
    if (pend && nw > 0) begin
      log_done_after[nw-1] = done;
      log_cpu_after[nw-1]  = cpu_rst;
      pend = 1'b0;
    end
    if (imem_we && nw < 64) begin
      log_addr[nw]    = 32'(imem_addr);
      log_data[nw]    = imem_wdata;
      log_done_at[nw] = done;
      nw   = nw + 1;
      pend = 1'b1;
      if (we_prev) b2b = b2b + 1;
    end
    we_prev = imem_we;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, ".imem_we"}, 32'(imem_we), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".loading"}, 32'(loading), 32'd0);
    check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
  endtask

  typedef struct {
    string             name;
    int                nb;
    logic [0:11][7:0]  b;
    logic [11:0]       bad;
    int                nw;
    logic [31:0]       a [2];
    logic [31:0]       d [2];
    logic              done_e, cpu_e, load_e, ferr_e;
  } vec_t;

  vec_t tbl [7];

  task automatic set_vec(input int i, input string name, input int nb, input logic [0:11][7:0] b,
                         input logic [11:0] bad, input int nwr,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic de, input logic ce, input logic le, input logic fe);
    tbl[i].name = name;  tbl[i].nb = nb;  tbl[i].b = b;  tbl[i].bad = bad;
    tbl[i].nw = nwr;
    tbl[i].a[0] = a0;  tbl[i].d[0] = d0;  tbl[i].a[1] = a1;  tbl[i].d[1] = d1;
    tbl[i].done_e = de;  tbl[i].cpu_e = ce;  tbl[i].load_e = le;  tbl[i].ferr_e = fe;
  endtask

  int base;

  initial begin
    set_vec(0, "two_word", 12,
            {8'h02,8'h00,8'h00,8'h00, 8'h93,8'h00,8'h50,8'h00, 8'h13,8'h01,8'h10,8'h00}, 12'h000,
            2, 0, 32'h0050_0093, 1, 32'h0010_0113, 1, 0, 0, 0);
    set_vec(1, "hdr_zero", 4,
            {8'h00,8'h00,8'h00,8'h00, 64'h0}, 12'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_vec(2, "hdr_17", 4,
            {8'h11,8'h00,8'h00,8'h00, 64'h0}, 12'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_vec(3, "frame_err", 9,
            {8'hA5, 8'h01,8'h00,8'h00,8'h00, 8'hEF,8'hBE,8'hAD,8'hDE, 24'h0}, 12'h001,
            1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 1);
    set_vec(4, "hdr_16_ok", 4,
            {8'h10,8'h00,8'h00,8'h00, 64'h0}, 12'h000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_vec(5, "after_done", 12,
            {8'h01,8'h00,8'h00,8'h00, 8'h78,8'h56,8'h34,8'h12, 8'hAA,8'hBB,8'hCC,8'hDD}, 12'h000,
            1, 0, 32'h1234_5678, 0, 0, 1, 0, 0, 0);
    set_vec(6, "partial_hdr", 2,
            {8'h01,8'h00, 80'h0}, 12'h000, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // Reset and quiescence.
    do_reset();
    #1;
    check_idle_outputs("reset");
    check("reset.imem_addr", 32'(imem_addr), 32'd0);
    check("reset.imem_wdata", imem_wdata, 32'd0);
    base = nw;
    repeat (1000) @(negedge clk);
    check_idle_outputs("quiet");
    check("quiet.writes", 32'(nw - base), 32'd0);

    // Table of complete byte streams.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      base = nw;
      for (int j = 0; j < tbl[i].nb; j++) send_byte(tbl[i].b[j], !tbl[i].bad[j]);
      repeat (40) @(negedge clk);
      check({tbl[i].name, ".writes"}, 32'(nw - base), 32'(tbl[i].nw));
      for (int k = 0; k < tbl[i].nw && k < 2 && base + k < nw; k++) begin
        check({tbl[i].name, ".addr"}, log_addr[base+k], tbl[i].a[k]);
        check({tbl[i].name, ".data"}, log_data[base+k], tbl[i].d[k]);
        check({tbl[i].name, ".done_at_we"}, 32'(log_done_at[base+k]), 32'd0);
      end
      if (tbl[i].done_e && nw > base) begin
        check({tbl[i].name, ".done_next"}, 32'(log_done_after[nw-1]), 32'd1);
        check({tbl[i].name, ".cpu_rst_next"}, 32'(log_cpu_after[nw-1]), 32'd0);
      end
      check({tbl[i].name, ".done"}, 32'(done), 32'(tbl[i].done_e));
      check({tbl[i].name, ".cpu_rst"}, 32'(cpu_rst), 32'(tbl[i].cpu_e));
      check({tbl[i].name, ".loading"}, 32'(loading), 32'(tbl[i].load_e));
      check({tbl[i].name, ".frame_err"}, 32'(frame_err), 32'(tbl[i].ferr_e));
    end

    // Glitch shorter than half a bit: nothing counted, next image still aligned.
    do_reset();
    base = nw;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch.loading", 32'(loading), 32'd0);
    check("glitch.frame_err", 32'(frame_err), 32'd0);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hC3, 1'b1); send_byte(8'hB2, 1'b1); send_byte(8'hA1, 1'b1); send_byte(8'h90, 1'b1);
    repeat (40) @(negedge clk);
    check("glitch.writes", 32'(nw - base), 32'd1);
    if (nw > base) begin
      check("glitch.addr", log_addr[base], 32'd0);
      check("glitch.data", log_data[base], 32'h90A1_B2C3);
    end
    check("glitch.done", 32'(done), 32'd1);

    // Reset in the middle of the first payload word, then a full resend.
    do_reset();
    base = nw;
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    check("midrst.loading_before", 32'(loading), 32'd1);
    do_reset();
    #1;
    check_idle_outputs("midrst");
    check("midrst.writes", 32'(nw - base), 32'd0);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    repeat (40) @(negedge clk);
    check("resend.writes", 32'(nw - base), 32'd1);
    if (nw > base) begin
      check("resend.addr", log_addr[base], 32'd0);
      check("resend.data", log_data[base], 32'h4433_2211);
    end
    check("resend.done", 32'(done), 32'd1);
    check("resend.cpu_rst", 32'(cpu_rst), 32'd0);

    check("no_back_to_back_writes", 32'(b2b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
